// File: rtl/ftdi_pkg.sv
// Shared types and constants for the FTDI 245-FIFO responder.
package ftdi_pkg;

    localparam int FTDI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACT,
        RD_GAP,
        WR_ACT,
        WR_GAP,
        ERR_HOLD
    } resp_state_e;

endpackage

// File: rtl/lb_sync_fifo.sv
// First-word fall-through synchronous FIFO with full/empty/count; pushes while full are dropped.
module lb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en, rd_en;

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + CNT_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; flushing is done by clearing the pointers.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ftdi_fifo_responder.sv
// FTDI-side emulation of the async 245-FIFO bus: answers rd_n/wr_n strobes from RX/TX buffers.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | flags follow buffer status, waiting for a strobe
//   RD_ACT   | read in progress, RX head driven, pop on rd_n release
//   RD_GAP   | rxf_n/txe_n forced high for RXF_GAP cycles after a read
//   WR_ACT   | write in progress, bus captured while wr_n low, push on release
//   WR_GAP   | rxf_n/txe_n forced high for TXE_GAP cycles after a write
//   ERR_HOLD | illegal strobe seen, wait for both strobes high
module ftdi_fifo_responder
    import ftdi_pkg::*;
#(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16,
    parameter int RXF_GAP  = 4,
    parameter int TXE_GAP  = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   rd_n,
    input  logic                   wr_n,
    input  logic [FTDI_BYTE_W-1:0] adbus_in,
    output logic [FTDI_BYTE_W-1:0] adbus_out,
    output logic                   adbus_oe,
    output logic                   rxf_n,
    output logic                   txe_n,
    input  logic [FTDI_BYTE_W-1:0] host_tx_data,
    input  logic                   host_tx_valid,
    output logic                   host_tx_ready,
    output logic [FTDI_BYTE_W-1:0] host_rx_data,
    output logic                   host_rx_valid,
    input  logic                   host_rx_ready,
    output logic                   proto_err,
    output logic [15:0]            rd_count,
    output logic [15:0]            wr_count
);

    localparam int GAP_MAX = (RXF_GAP > TXE_GAP) ? RXF_GAP : TXE_GAP;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);
    localparam logic [GAP_W-1:0] RX_GAP_LOAD = GAP_W'(RXF_GAP - 1);
    localparam logic [GAP_W-1:0] TX_GAP_LOAD = GAP_W'(TXE_GAP - 1);

    resp_state_e            state_q, state_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [FTDI_BYTE_W-1:0] wr_hold_q, wr_hold_d;
    logic                   rxf_n_q, rxf_n_d;
    logic                   txe_n_q, txe_n_d;
    logic                   err_q, err_d;
    logic [15:0]            rd_cnt_q, rd_cnt_d;
    logic [15:0]            wr_cnt_q, wr_cnt_d;

    logic                   rx_pop, tx_push;
    logic                   rx_full, rx_empty, tx_full, tx_empty;
    logic [FTDI_BYTE_W-1:0] rx_head, tx_head;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic                   unused_counts;

    assign unused_counts = ^{rx_count, tx_count};

    lb_sync_fifo #(.WIDTH(FTDI_BYTE_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (host_tx_valid),
        .din     (host_tx_data),
        .pop     (rx_pop),
        .dout    (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    lb_sync_fifo #(.WIDTH(FTDI_BYTE_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (tx_push),
        .din     (wr_hold_q),
        .pop     (host_rx_ready),
        .dout    (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        wr_hold_d = wr_hold_q;
        err_d     = err_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        rx_pop    = 1'b0;
        tx_push   = 1'b0;
        rxf_n_d   = 1'b1;
        txe_n_d   = 1'b1;

        case (state_q)
            IDLE: begin
                if (!rd_n || !wr_n) begin
                    if (!rd_n && wr_n && !rxf_n_q) begin
                        state_d = RD_ACT;
                    end else if (!wr_n && rd_n && !txe_n_q) begin
                        state_d   = WR_ACT;
                        wr_hold_d = adbus_in;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERR_HOLD;
                    end
                end
            end
            RD_ACT: begin
                if (!wr_n) err_d = 1'b1;
                if (rd_n) begin
                    rx_pop   = 1'b1;
                    rd_cnt_d = rd_cnt_q + 16'd1;
                    gap_d    = RX_GAP_LOAD;
                    state_d  = RD_GAP;
                end
            end
            WR_ACT: begin
                if (!rd_n) err_d = 1'b1;
                if (!wr_n) begin
                    wr_hold_d = adbus_in;
                end else begin
                    tx_push  = 1'b1;
                    wr_cnt_d = wr_cnt_q + 16'd1;
                    gap_d    = TX_GAP_LOAD;
                    state_d  = WR_GAP;
                end
            end
            RD_GAP, WR_GAP: begin
                if (gap_q == '0) state_d = IDLE;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            ERR_HOLD: begin
                if (rd_n && wr_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flags only open up again once the FSM is back in IDLE.
        if (state_d == IDLE) begin
            rxf_n_d = rx_empty;
            txe_n_d = tx_full;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            wr_hold_q <= '0;
            rxf_n_q   <= 1'b1;
            txe_n_q   <= 1'b1;
            err_q     <= 1'b0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            wr_hold_q <= wr_hold_d;
            rxf_n_q   <= rxf_n_d;
            txe_n_q   <= txe_n_d;
            err_q     <= err_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    // Zero-latency drive so the master can capture in the cycle rd_n falls.
    assign adbus_oe  = !rd_n && ((state_q == RD_ACT) || ((state_q == IDLE) && !rxf_n_q));
    assign adbus_out = adbus_oe ? rx_head : '0;

    assign rxf_n         = rxf_n_q;
    assign txe_n         = txe_n_q;
    assign proto_err     = err_q;
    assign rd_count      = rd_cnt_q;
    assign wr_count      = wr_cnt_q;
    assign host_tx_ready = !rx_full;
    assign host_rx_valid = !tx_empty;
    assign host_rx_data  = tx_head;

endmodule

// File: tb/tb_ftdi_fifo_responder.sv
// Scoreboard bench for ftdi_fifo_responder: expected bytes queued at stimulus, checked by a monitor.
module tb_ftdi_fifo_responder;

    localparam int RX_DEPTH = 16;
    localparam int TX_DEPTH = 16;
    localparam int RXF_GAP  = 4;
    localparam int TXE_GAP  = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        rd_n, wr_n;
    logic [7:0]  adbus_in, adbus_out;
    logic        adbus_oe, rxf_n, txe_n;
    logic [7:0]  host_tx_data, host_rx_data;
    logic        host_tx_valid, host_tx_ready;
    logic        host_rx_valid, host_rx_ready;
    logic        proto_err;
    logic [15:0] rd_count, wr_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_rd[$];
    logic [7:0] exp_tx[$];
    logic       oe_prev = 1'b0;

    always #5 clock = ~clock;

    ftdi_fifo_responder #(
        .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH), .RXF_GAP(RXF_GAP), .TXE_GAP(TXE_GAP)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .rd_n          (rd_n),
        .wr_n          (wr_n),
        .adbus_in      (adbus_in),
        .adbus_out     (adbus_out),
        .adbus_oe      (adbus_oe),
        .rxf_n         (rxf_n),
        .txe_n         (txe_n),
        .host_tx_data  (host_tx_data),
        .host_tx_valid (host_tx_valid),
        .host_tx_ready (host_tx_ready),
        .host_rx_data  (host_rx_data),
        .host_rx_valid (host_rx_valid),
        .host_rx_ready (host_rx_ready),
        .proto_err     (proto_err),
        .rd_count      (rd_count),
        .wr_count      (wr_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: bus reads and host-side drains are checked against the queues.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (adbus_oe && !oe_prev && wr_n) begin
                    if (exp_rd.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rd_unexpected actual=%0h expected=none", adbus_out);
                    end else begin
                        chk("rd_data", 32'(adbus_out), 32'(exp_rd.pop_front()));
                    end
                end
                if (host_rx_valid && host_rx_ready) begin
                    if (exp_tx.size() == 0) begin
                        total++; bad++;
                        $display("FAIL tx_unexpected actual=%0h expected=none", host_rx_data);
                    end else begin
                        chk("tx_data", 32'(host_rx_data), 32'(exp_tx.pop_front()));
                    end
                end
            end
            oe_prev = adbus_oe;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic host_push(input logic [7:0] b);
        host_tx_data  = b;
        host_tx_valid = 1'b1;
        tick();
        host_tx_valid = 1'b0;
    endtask

    task automatic wait_rxf(output int n);
        n = 0;
        while (rxf_n !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk("rxf_wait", 32'(rxf_n), 0);
    endtask

    task automatic wait_txe();
        int n = 0;
        while (txe_n !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk("txe_wait", 32'(txe_n), 0);
    endtask

    task automatic master_read(input logic [7:0] b, output int gap);
        exp_rd.push_back(b);
        wait_rxf(gap);
        rd_n = 1'b0;
        tick();
        tick();
        rd_n = 1'b1;
    endtask

    task automatic master_write(input logic [7:0] b);
        exp_tx.push_back(b);
        wait_txe();
        wr_n     = 1'b0;
        adbus_in = b;
        tick();
        tick();
        wr_n     = 1'b1;
        adbus_in = 8'h00;
    endtask

    task automatic host_drain();
        int n = 0;
        host_rx_ready = 1'b1;
        while (host_rx_valid && n < 200) begin
            tick();
            n++;
        end
        host_rx_ready = 1'b0;
        chk("drain_done", 32'(host_rx_valid), 0);
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        rd_n          = 1'b1;
        wr_n          = 1'b1;
        adbus_in      = 8'h00;
        host_tx_valid = 1'b0;
        host_rx_ready = 1'b0;
        exp_rd.delete();
        exp_tx.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        reset_n       = 1'b0;
        rd_n          = 1'b1;
        wr_n          = 1'b1;
        adbus_in      = 8'h00;
        host_tx_data  = 8'h00;
        host_tx_valid = 1'b0;
        host_rx_ready = 1'b0;
        tick();
        tick();
        chk("rst_rxf_n", 32'(rxf_n), 1);
        chk("rst_txe_n", 32'(txe_n), 1);
        chk("rst_oe", 32'(adbus_oe), 0);
        chk("rst_out", 32'(adbus_out), 0);
        chk("rst_err", 32'(proto_err), 0);
        chk("rst_rd_count", 32'(rd_count), 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        chk("rst_rx_valid", 32'(host_rx_valid), 0);
        chk("rst_tx_ready", 32'(host_tx_ready), 1);
        reset_n = 1'b1;
        tick();

        // Two host bytes read back in order, with a flag gap between reads.
        host_push(8'hA5);
        host_push(8'h3C);
        master_read(8'hA5, g);
        master_read(8'h3C, g);
        chk("rxf_gap_ok", 32'(g >= RXF_GAP), 1);
        tick();
        tick();
        chk("t1_rd_count", 32'(rd_count), 2);
        chk("t1_err", 32'(proto_err), 0);

        // Fill TX with 16 writes, confirm it stays full, then drain in order.
        for (int i = 0; i < 16; i++) master_write(8'(8'h11 + i));
        repeat (10) tick();
        chk("t2_txe_full", 32'(txe_n), 1);
        chk("t2_rx_valid", 32'(host_rx_valid), 1);
        chk("t2_wr_count", 32'(wr_count), 16);
        host_drain();
        chk("t2_txq_empty", 32'(exp_tx.size()), 0);
        repeat (8) tick();
        chk("t2_txe_open", 32'(txe_n), 0);

        // Read strobe against an empty RX buffer.
        do_reset();
        rd_n = 1'b0;
        @(negedge clock);
        chk("t3_oe", 32'(adbus_oe), 0);
        chk("t3_out", 32'(adbus_out), 0);
        tick();
        tick();
        rd_n = 1'b1;
        repeat (3) tick();
        chk("t3_err", 32'(proto_err), 1);
        chk("t3_rd_count", 32'(rd_count), 0);
        host_push(8'hC3);
        master_read(8'hC3, g);
        tick();
        tick();
        chk("t3_recover_count", 32'(rd_count), 1);
        chk("t3_err_sticky", 32'(proto_err), 1);

        // Both strobes low together while both flags are low.
        do_reset();
        host_push(8'h81);
        wait_rxf(g);
        wait_txe();
        rd_n     = 1'b0;
        wr_n     = 1'b0;
        adbus_in = 8'h77;
        tick();
        tick();
        rd_n     = 1'b1;
        wr_n     = 1'b1;
        adbus_in = 8'h00;
        repeat (3) tick();
        chk("t4_err", 32'(proto_err), 1);
        chk("t4_rd_count", 32'(rd_count), 0);
        chk("t4_wr_count", 32'(wr_count), 0);
        chk("t4_no_push", 32'(host_rx_valid), 0);
        master_read(8'h81, g);
        tick();
        tick();
        chk("t4_byte_kept", 32'(rd_count), 1);

        // Host push and FPGA pop land in the same cycle at RX_DEPTH-1.
        do_reset();
        for (int i = 0; i < RX_DEPTH - 1; i++) host_push(8'(8'h40 + i));
        exp_rd.push_back(8'h40);
        wait_rxf(g);
        rd_n = 1'b0;
        tick();
        tick();
        rd_n          = 1'b1;
        host_tx_data  = 8'h4F;
        host_tx_valid = 1'b1;
        tick();
        host_tx_valid = 1'b0;
        chk("t5_ready_after", 32'(host_tx_ready), 1);
        host_push(8'h50);
        chk("t5_full", 32'(host_tx_ready), 0);
        for (int i = 1; i <= RX_DEPTH; i++) master_read(8'(8'h40 + i), g);
        tick();
        tick();
        chk("t5_rd_count", 32'(rd_count), RX_DEPTH + 1);
        chk("t5_rdq_empty", 32'(exp_rd.size()), 0);

        // Reset pulse in the middle of a write.
        do_reset();
        host_push(8'hEE);
        master_write(8'h33);
        wait_txe();
        wr_n     = 1'b0;
        adbus_in = 8'h99;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("t6_oe", 32'(adbus_oe), 0);
        chk("t6_rxf_n", 32'(rxf_n), 1);
        chk("t6_txe_n", 32'(txe_n), 1);
        chk("t6_wr_count", 32'(wr_count), 0);
        chk("t6_tx_empty", 32'(host_rx_valid), 0);
        chk("t6_rx_flushed", 32'(host_tx_ready), 1);
        wr_n     = 1'b1;
        adbus_in = 8'h00;
        exp_tx.delete();
        exp_rd.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        master_write(8'h5A);
        repeat (2) tick();
        chk("t6_wr_count_after", 32'(wr_count), 1);
        host_drain();
        chk("t6_txq_empty", 32'(exp_tx.size()), 0);
        chk("t6_rd_count", 32'(rd_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
